disp_scan_driver: RTL and testbench
===================================

# disp_scan_driver

Parametrised successor of the calculator's display selector. It picks the value to show from the calculator FSM state, converts it to hex or decimal digits, and time-multiplexes the digits onto a common-anode seven-segment bank. Decimal conversion uses a sequential shift-add-3 converter. Sits between the calculator FSM/ALU and the board's AN/SEG/DP pins.

## Interface
- N_DIGITS, 8: number of digits scanned (1..8).
- SW_W, 16: switch operand width.
- RES_W, 17: ALU result width; MSB is the carry/overflow flag.
- SCAN_DIV, 100000: clk cycles per digit slot (≥2).
- VAL_W: derived, max(SW_W, RES_W-1); width of the displayed value.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- state  in  3  calculator FSM state.
- SW  in  SW_W  switch operand.
- res  in  RES_W  ALU result.
- dec_mode  in  1  1 = decimal display, 0 = hex.
- AN  out  N_DIGITS  digit enables, active low, one-hot.
- SEG  out  7  segments {g..a}, active low.
- DP  out  1  decimal point, active low.
- busy  out  1  decimal conversion in progress.

## Operation
- Source select, registered every cycle:
  - 000/001: value = SW zero-extended to VAL_W.
  - 010: display blanked (all AN high).
  - 011: value = res[RES_W-2:0], ovf = res[RES_W-1].
  - Other states: value = 0.
- Hex mode: digit k = value[4k+3:4k]. Takes effect one cycle after value is captured.
- Decimal mode: bin2bcd_seq converts value; displayed digits are the last completed conversion.
  - A conversion starts when the converter is idle and (value, dec_mode) differs from the snapshot taken at the last start.
  - A value change during a conversion does not abort it. The next conversion starts the cycle after done.
- Decimal overflow: if value > 10^N_DIGITS − 1, every digit shows a dash (segment g only).
- Leading-zero suppression: digits above the most significant non-zero digit are blank. Digit 0 is always shown (value 0 shows "0").
- DP: digit 0's DP is lit when state = 011 and ovf = 1. All other DPs are off.
- Scan: a prescaler counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→N_DIGITS-1→0. AN[idx] is low; all other AN bits are high.
- Converter FSM (bin2bcd_seq): IDLE → SHIFT (VAL_W cycles, add-3 on each BCD nibble ≥5, then shift) → DONE (1 cycle, result latched) → IDLE. busy = 1 in SHIFT and DONE.
- Segment patterns come from the package lookup for 0–F, dash and blank.

## Timing
- Reset values: AN all 1, SEG 7'h7F, DP 1, busy 0, digit index 0, prescaler 0, displayed digits all 0, converter IDLE, snapshot 0.
- The first digit is enabled on the cycle after reset deasserts: AN = ~1, showing "0".
- AN/SEG/DP are registered together, so there are no glitch cycles with mismatched anode and segment.
- Hex latency, from an input change to new SEG content in the digit slot: 2 cycles.
- Decimal latency: VAL_W + 3 cycles after an idle converter sees a change (1 start + VAL_W shift + 1 done + 1 output register).
- Entering state 010 blanks AN on the next cycle. Leaving it restores scanning at the current index without resetting the prescaler.
- A dec_mode toggle mid-conversion lets the conversion finish, then the converter reconverts. Hex digits switch immediately.
- Reset mid-conversion returns all state to the reset values within the same cycle (asynchronous).

## Structure
- disp_pkg holds:
  - state encodings: ST_IN_A = 3'b000, ST_IN_B = 3'b001, ST_CALC = 3'b010, ST_SHOW = 3'b011;
  - the seven-segment lookup function for 0–F;
  - the SEG_DASH and SEG_BLANK constants.
- Sub-module bin2bcd_seq (parameters IN_W, N_DIGITS; ports start, bin, bcd, done, busy) holds the conversion FSM. The top level holds source select, change detect, zero suppression, prescaler and scan.

## Test plan
All scenarios use SCAN_DIV = 4.
- Reset check: pulse reset mid-scan → AN = 8'hFF, SEG = 7'h7F, busy = 0 immediately. After release, AN steps 8'hFE→8'hFD every 4 cycles.
- Hex, leading-zero suppression: state = 000, SW = 16'h00A5, dec_mode = 0 → digit 0 shows "5", digit 1 shows "A", digits 2–7 are blank.
- Decimal conversion: state = 011, res = 17'h0FFFF, dec_mode = 1 → busy high for 17 cycles. The display then reads 65535, digits 5–7 are blank, and DP is off.
- Overflow flag: state = 011, res = 17'h10000 → digit 0 shows "0" with DP lit.
- Blanking: state = 010 → AN = 8'hFF next cycle. Returning to 000 resumes scan at the held index.
- Change during conversion: change SW from 123 to 456 mid-SHIFT → 123 is displayed first, then a second busy pulse, then 456.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package disp_pkg;

  // Calculator FSM state encodings seen by the display.
  localparam logic [2:0] ST_IN_A = 3'b000;
  localparam logic [2:0] ST_IN_B = 3'b001;
  localparam logic [2:0] ST_CALC = 3'b010;
  localparam logic [2:0] ST_SHOW = 3'b011;

  // Segment bits are {g,f,e,d,c,b,a}, active low.
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    CV_IDLE  = 2'd0,
    CV_SHIFT = 2'd1,
    CV_DONE  = 2'd2
  } cv_state_e;

  function automatic logic [6:0] seg_hex(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // 10^n, used to find the largest value that fits in n decimal digits.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/disp_scan_driver_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle.
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int N_DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  done,
  output logic                  busy
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int BCD_W = 4 * N_DIGITS;

  cv_state_e          st_q;
  logic [IN_W-1:0]    sh_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   adj_d;
  logic [CNT_W-1:0]   cnt_q;

  // Add 3 to every nibble that is 5 or more before the next shift.
  always_comb begin
    adj_d = bcd_q;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj_d[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Conversion FSM: load on start, shift IN_W times, hold result for one DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q  <= CV_IDLE;
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      case (st_q)
        CV_IDLE: begin
          if (start) begin
            sh_q  <= bin;
            bcd_q <= '0;
            cnt_q <= '0;
            st_q  <= CV_SHIFT;
          end
        end
        CV_SHIFT: begin
          {bcd_q, sh_q} <= {adj_d[BCD_W-2:0], sh_q, 1'b0};
          cnt_q         <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(IN_W - 1)) st_q <= CV_DONE;
        end
        CV_DONE: st_q <= CV_IDLE;
        default: st_q <= CV_IDLE;
      endcase
    end
  end

  assign bcd  = bcd_q;
  assign done = (st_q == CV_DONE);
  assign busy = (st_q != CV_IDLE);

endmodule

// File: rtl/disp_scan_driver.sv
// Picks the calculator value to show, formats it as hex or decimal digits
// and time-multiplexes them onto a common-anode seven-segment bank.
module disp_scan_driver
  import disp_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int SW_W     = 16,
  parameter int RES_W    = 17,
  parameter int SCAN_DIV = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          state,
  input  logic [SW_W-1:0]     SW,
  input  logic [RES_W-1:0]    res,
  input  logic                dec_mode,
  output logic [N_DIGITS-1:0] AN,
  output logic [6:0]          SEG,
  output logic                DP,
  output logic                busy
);

  localparam int VAL_W = max_i(SW_W, RES_W - 1);
  localparam int HEX_W = max_i(VAL_W, 4 * N_DIGITS);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [63:0] DEC_MAX = pow10(N_DIGITS) - 64'd1;

  // Source select
  logic [VAL_W-1:0] val_d, val_q;
  logic             ovf_d, ovf_q;
  logic             mode_q;

  // Change detect / converter
  logic [VAL_W-1:0]              snap_val_q;
  logic                          snap_mode_q;
  logic                          cv_start, cv_done, cv_busy;
  logic [4*N_DIGITS-1:0]         cv_bcd;
  logic [N_DIGITS-1:0][3:0]      dec_dig_q;
  logic                          dec_ovf_q;

  // Digit formatting
  logic [HEX_W-1:0]              hex_w;
  logic [N_DIGITS-1:0][3:0]      raw_d;
  logic [N_DIGITS-1:0]           lit_d;
  logic                          seen_d;
  logic [6:0]                    seg_d;

  // Scan
  logic                          blank;
  logic [CNT_W-1:0]              cnt_q;
  logic [IDX_W-1:0]              idx_q;
  logic [N_DIGITS-1:0]           an_q;
  logic [6:0]                    seg_q;
  logic                          dp_q;

  // Value and overflow flag chosen by the calculator state.
  always_comb begin
    val_d = '0;
    ovf_d = 1'b0;
    case (state)
      ST_IN_A, ST_IN_B: val_d = VAL_W'(SW);
      ST_SHOW: begin
        val_d = VAL_W'(res[RES_W-2:0]);
        ovf_d = res[RES_W-1];
      end
      default: ;
    endcase
  end

  // Source registers, refreshed every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q  <= '0;
      ovf_q  <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      ovf_q  <= ovf_d;
      mode_q <= dec_mode;
    end
  end

  // A new conversion only when idle and the value/mode differs from the last started one;
  // changes seen mid-conversion are picked up after it completes.
  assign cv_start = !cv_busy && ((val_q != snap_val_q) || (mode_q != snap_mode_q));

  bin2bcd_seq #(
    .IN_W     (VAL_W),
    .N_DIGITS (N_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (cv_start),
    .bin   (val_q),
    .bcd   (cv_bcd),
    .done  (cv_done),
    .busy  (cv_busy)
  );

  // Snapshot of the converted inputs, and latch of each finished conversion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_val_q  <= '0;
      snap_mode_q <= 1'b0;
      dec_dig_q   <= '0;
      dec_ovf_q   <= 1'b0;
    end else begin
      if (cv_start) begin
        snap_val_q  <= val_q;
        snap_mode_q <= mode_q;
      end
      if (cv_done) begin
        dec_dig_q <= cv_bcd;
        dec_ovf_q <= (64'(snap_val_q) > DEC_MAX);
      end
    end
  end

  assign hex_w = HEX_W'(val_q);

  // Raw digits and leading-zero suppression; digit 0 is always lit.
  always_comb begin
    raw_d  = '0;
    lit_d  = '0;
    seen_d = 1'b0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      raw_d[k] = mode_q ? dec_dig_q[k] : hex_w[4*k +: 4];
      if (raw_d[k] != 4'd0) seen_d = 1'b1;
      lit_d[k] = seen_d || (k == 0);
    end
  end

  // Segment pattern for the digit currently being scanned.
  always_comb begin
    seg_d = SEG_BLANK;
    if (mode_q && dec_ovf_q) seg_d = SEG_DASH;
    else if (lit_d[idx_q])   seg_d = seg_hex(raw_d[idx_q]);
  end

  // Blanking follows the state input directly so AN goes dark on the next edge.
  assign blank = (state == ST_CALC);

  // Prescaler runs continuously; the digit index holds while blanked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_q <= '0;
      if (!blank) idx_q <= (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Anode, segment and DP registered together so they never disagree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else if (blank) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= ~(N_DIGITS'(1) << idx_q);
      seg_q <= seg_d;
      dp_q  <= !((idx_q == '0) && ovf_q);
    end
  end

  assign AN   = an_q;
  assign SEG  = seg_q;
  assign DP   = dp_q;
  assign busy = cv_busy;

endmodule

// File: tb/tb_disp_scan_driver.sv
// Directed bench for disp_scan_driver: an 8-digit and a 4-digit instance, SCAN_DIV = 4.
module tb_disp_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  st;
  logic [15:0] sw;
  logic [16:0] res;
  logic        dec;

  logic [7:0]  an8;
  logic [6:0]  seg8;
  logic        dp8, busy8;
  logic [3:0]  an4;
  logic [6:0]  seg4;
  logic        dp4, busy4;

  int checks = 0;
  int errors = 0;

  logic [7:0][6:0] cap8;
  logic [7:0]      dpc8;
  logic [3:0][6:0] cap4;
  logic [3:0]      dpc4;

  typedef struct {
    logic [2:0]      st;
    logic [15:0]     sw;
    logic [16:0]     res;
    logic            dec;
    logic [7:0][6:0] seg;
    logic [7:0]      dp;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  disp_scan_driver #(.N_DIGITS(8), .SW_W(16), .RES_W(17), .SCAN_DIV(4)) dut8 (
    .clk(clk), .reset(rst), .state(st), .SW(sw), .res(res), .dec_mode(dec),
    .AN(an8), .SEG(seg8), .DP(dp8), .busy(busy8)
  );

  disp_scan_driver #(.N_DIGITS(4), .SW_W(16), .RES_W(17), .SCAN_DIV(4)) dut4 (
    .clk(clk), .reset(rst), .state(st), .SW(sw), .res(res), .dec_mode(dec),
    .AN(an4), .SEG(seg4), .DP(dp4), .busy(busy4)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic [2:0] s, input logic [15:0] w, input logic [16:0] r,
                      input logic d, input logic [7:0][6:0] sg, input logic [7:0] p);
    vec_t v;
    v.st = s; v.sw = w; v.res = r; v.dec = d; v.seg = sg; v.dp = p;
    vecs.push_back(v);
  endtask

  // Record the segment/DP pattern seen in each digit slot over n cycles.
  task automatic capture(input int n);
    cap8 = {8{7'h55}}; dpc8 = 8'h00;
    cap4 = {4{7'h55}}; dpc4 = 4'h0;
    for (int c = 0; c < n; c++) begin
      tick();
      for (int k = 0; k < 8; k++)
        if (an8 == ~(8'd1 << k)) begin cap8[k] = seg8; dpc8[k] = dp8; end
      for (int k = 0; k < 4; k++)
        if (an4 == ~(4'd1 << k)) begin cap4[k] = seg4; dpc4[k] = dp4; end
    end
  endtask

  task automatic wait_busy4(input logic lvl, input string nm);
    int n = 0;
    while (busy4 !== lvl && n < 100) begin tick(); n++; end
    chk(nm, 64'(busy4), 64'(lvl));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Vectors for the 8-digit instance: {state, SW, res, dec_mode, SEG digits 7..0, DP 7..0}
    addv(3'b000, 16'h00A5, 17'h0, 1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h08,7'h12}, 8'hFF);
    addv(3'b011, 16'h0, 17'h0FFFF, 1'b1, {7'h7F,7'h7F,7'h7F,7'h02,7'h12,7'h12,7'h30,7'h12}, 8'hFF);
    addv(3'b011, 16'h0, 17'h10000, 1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40}, 8'hFE);
    addv(3'b001, 16'h1234, 17'h0, 1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h24,7'h30,7'h19}, 8'hFF);
    addv(3'b000, 16'hFFFF, 17'h0, 1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h0E,7'h0E,7'h0E,7'h0E}, 8'hFF);
    addv(3'b000, 16'h0000, 17'h0, 1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40}, 8'hFF);
    addv(3'b100, 16'h1234, 17'h0, 1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40}, 8'hFF);
    addv(3'b000, 16'd1000, 17'h0, 1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h40,7'h40,7'h40}, 8'hFF);
    addv(3'b011, 16'h0, 17'h1FFFF, 1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h0E,7'h0E,7'h0E,7'h0E}, 8'hFE);
    addv(3'b011, 16'h0, 17'h0FFFF, 1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h0E,7'h0E,7'h0E,7'h0E}, 8'hFF);
    addv(3'b000, 16'd9, 17'h0, 1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h10}, 8'hFF);

    // Reset pulse in the middle of a conversion and a scan.
    st = 3'b000; sw = 16'd50; res = '0; dec = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("busy_mid_conv", 64'(busy8), 64'(1'b1));
    #2 rst = 1'b1;
    #1;
    chk("rst_an", 64'(an8), 64'(8'hFF));
    chk("rst_seg", 64'(seg8), 64'(7'h7F));
    chk("rst_busy", 64'(busy8), 64'(1'b0));
    chk("rst_an4", 64'(an4), 64'(4'hF));
    tick();
    rst = 1'b0;

    // Scan restart, then blanking with index hold and free-running prescaler.
    tick();
    chk("an_e1", 64'(an8), 64'(8'hFE));
    chk("seg_e1", 64'(seg8), 64'(7'h40));
    for (int e = 2; e <= 4; e++) begin tick(); chk("an_slot0", 64'(an8), 64'(8'hFE)); end
    tick(); chk("an_e5", 64'(an8), 64'(8'hFD));
    tick(); st = 3'b010;
    tick();
    chk("blank_an", 64'(an8), 64'(8'hFF));
    chk("blank_seg", 64'(seg8), 64'(7'h7F));
    repeat (9) tick();
    st = 3'b000;
    tick(); chk("resume_an", 64'(an8), 64'(8'hFD));
    repeat (3) tick(); chk("resume_hold", 64'(an8), 64'(8'hFD));
    tick(); chk("resume_step", 64'(an8), 64'(8'hFB));

    // Hex path latency on the 4-digit instance.
    dec = 1'b0; sw = 16'h1111;
    repeat (10) tick();
    sw = 16'h2222;
    tick(); chk("hex_lat1", 64'(seg4), 64'(7'h79));
    tick(); chk("hex_lat2", 64'(seg4), 64'(7'h24));

    // Decimal conversion length.
    sw = 16'h0;
    repeat (45) tick();
    st = 3'b011; res = 17'h0FFFF; dec = 1'b1;
    tick(); chk("busy_e1", 64'(busy8), 64'(1'b0));
    tick(); chk("busy_e2", 64'(busy8), 64'(1'b1));
    n = 0;
    while (busy8 === 1'b1 && n < 100) begin n++; tick(); end
    chk("busy_len", 64'(n), 64'(17));

    // Value change during a conversion: first result shown, then a second pass.
    st = 3'b000; sw = 16'd0;
    repeat (45) tick();
    sw = 16'd123;
    wait_busy4(1'b1, "busy_rise1");
    repeat (5) tick();
    sw = 16'd456;
    wait_busy4(1'b0, "busy_fall1");
    capture(16);
    chk("dec_first", 64'(cap4), 64'({7'h7F,7'h79,7'h24,7'h30}));
    chk("busy_second", 64'(busy4), 64'(1'b1));
    wait_busy4(1'b0, "busy_fall2");
    repeat (2) tick();
    capture(20);
    chk("dec_second", 64'(cap4), 64'({7'h7F,7'h19,7'h12,7'h02}));

    // Decimal overflow boundary on the 4-digit instance.
    sw = 16'd9999;
    repeat (45) tick();
    capture(20);
    chk("ovf4_9999", 64'(cap4), 64'({7'h10,7'h10,7'h10,7'h10}));
    sw = 16'd10000;
    repeat (45) tick();
    capture(20);
    chk("ovf4_10000", 64'(cap4), 64'({7'h3F,7'h3F,7'h3F,7'h3F}));
    chk("ovf4_dp", 64'(dpc4), 64'(4'hF));

    // Table of static display cases on the 8-digit instance.
    foreach (vecs[i]) begin
      st = vecs[i].st; sw = vecs[i].sw; res = vecs[i].res; dec = vecs[i].dec;
      repeat (45) tick();
      capture(34);
      chk($sformatf("vec%0d_seg", i), 64'(cap8), 64'(vecs[i].seg));
      chk($sformatf("vec%0d_dp", i), 64'(dpc8), 64'(vecs[i].dp));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
